display_mux: RTL and testbench

Time-multiplexing controller that shares the single combinational hex-to-7-segment decoder between up to four common-anode digits. Each cycle it selects one digit's nibble for the decoder input and drives that digit's active-low anode enable. A fixed blanking interval between digits prevents ghosting. A frame-synchronous shadow register keeps the displayed value from tearing mid-frame. Sits between the board-level digit sources (switches, counters) and the shared segment decoder.

---
 rtl/display_mux.sv | 191 +++++++++++++++++++
 tb/tb_display_mux.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/display_mux.sv
// -----------------------------------------------------------------------------
// display_mux
//
// Time-multiplexes up to four common-anode 7-segment digits onto one shared
// hex-to-7-segment decoder. Each digit slot is a blanking interval (all anodes
// off) followed by a lit interval (one anode low). The displayed value comes
// from a shadow register that only changes at a frame boundary, so a frame
// never shows a mix of old and new digits.
//
// Parameters
//   NUM_DIGITS   : number of multiplexed digits, 1..4
//   ON_CYCLES    : cycles a digit is lit per slot, >= 1
//   BLANK_CYCLES : cycles all anodes are off before each digit, >= 1
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   digits      in   4*NUM_DIGITS, digit i at [4i+3:4i], digit 0 rightmost
//   load        in   single-cycle strobe, captures digits for the next frame
//   s           out  4-bit nibble to the shared decoder (registered)
//   an          out  NUM_DIGITS active-low anode enables (registered)
//   frame_start out  one-cycle pulse on entry to digit 0's blanking slot
//   state_dbg   out  current FSM state (0 = BLANK, 1 = ON)
//
// Optional feature macro: DISPLAY_MUX_LEADING_ZERO_BLANK_EN
//   When defined, a digit idx > 0 stays dark in its ON slot if it and every
//   more significant shadow digit are zero. Slot timing is unaffected.
// -----------------------------------------------------------------------------
module display_mux #(
  parameter int NUM_DIGITS   = 2,
  parameter int ON_CYCLES    = 20000,
  parameter int BLANK_CYCLES = 400
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  output logic [3:0]              s,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    state_dbg
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW      = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_ON    = CNT_W'(ON_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [3:0]            s_q, s_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fs_q, fs_d;
  logic                  boundary;

  // hi_zero[i] is set when shadow digits i..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS-1:0] hi_zero;

  // ---------------------------------------------------------------------------
  // Slot sequencing and shadow update.
  //
  // load is a fire-and-forget strobe with no back-pressure: the block always
  // accepts it. On the wrapping ON->BLANK edge it goes straight into the
  // shadow; on any other edge it is parked in pending (last one wins) and
  // promoted at the next frame boundary.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    boundary   = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == LAST_BLANK) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (cnt_q == LAST_ON) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    if (load) begin
      if (boundary) begin
        shadow_d   = digits;
        pend_vld_d = 1'b0;
      end else begin
        pending_d  = digits;
        pend_vld_d = 1'b1;
      end
    end else if (boundary && pend_vld_q) begin
      shadow_d   = pending_q;
      pend_vld_d = 1'b0;
    end
  end

`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
  // Scan from the most significant digit down, accumulating "all zero so far".
  always_comb begin
    logic run;
    run     = 1'b1;
    hi_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run        = run & (shadow_d[4*i +: 4] == 4'h0);
      hi_zero[i] = run;
    end
  end
`else
  assign hi_zero = '0;
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs are computed from next-state values so they line up
  // with the state they describe. s follows the shadow digit being entered,
  // which also picks up a value written on the boundary edge itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_d  = 4'h0;
    an_d = '1;
    fs_d = boundary;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        s_d = shadow_d[4*i +: 4];
      end
      if ((state_d == ST_ON) && (idx_d == IDX_W'(i)) && !((i > 0) && hi_zero[i])) begin
        an_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      s_q        <= 4'h0;
      an_q       <= '1;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      s_q        <= s_d;
      an_q       <= an_d;
      fs_q       <= fs_d;
    end
  end

  assign s           = s_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_display_mux.sv
// -----------------------------------------------------------------------------
// tb_display_mux
//
// Directed bench for display_mux with NUM_DIGITS=2, ON_CYCLES=4,
// BLANK_CYCLES=2 (slot 6 cycles, frame 12 cycles). Frame phase p counts from
// the first cycle of digit 0's blanking slot:
//   p 0..1  BLANK digit 0   an=11  s=digit0
//   p 2..5  ON    digit 0   an=10  s=digit0
//   p 6..7  BLANK digit 1   an=11  s=digit1
//   p 8..11 ON    digit 1   an=01  s=digit1 (11 if leading zero suppressed)
// frame_start is high at p=0 except in the first frame after reset.
// -----------------------------------------------------------------------------
module tb_display_mux;

  localparam int ND = 2;

`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
  localparam bit LZ_ON = 1'b1;
`else
  localparam bit LZ_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [4*ND-1:0] digits;
  logic          load;
  logic [3:0]    s;
  logic [ND-1:0] an;
  logic          frame_start;
  logic          state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_q[$];

  display_mux #(
    .NUM_DIGITS   (ND),
    .ON_CYCLES    (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .load        (load),
    .s           (s),
    .an          (an),
    .frame_start (frame_start),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Runs one 12-cycle frame starting at phase 0, checking every cycle against
  // the hand-derived slot pattern. Loads are driven at phases ph_a / ph_b and
  // are captured on the edge that ends that phase.
  task automatic run_frame(input logic [3:0] s0, input logic [3:0] s1, input logic fs0,
                           input int ph_a, input logic [7:0] val_a,
                           input int ph_b, input logic [7:0] val_b);
    logic       sup;
    logic [1:0] exp_an;
    sup = LZ_ON && (s1 == 4'h0);
    for (int p = 0; p < 12; p++) begin
      if (p >= 2 && p <= 5)  exp_q.push_back(2'b10);
      else if (p >= 8)       exp_q.push_back(sup ? 2'b11 : 2'b01);
      else                   exp_q.push_back(2'b11);
    end
    for (int p = 0; p < 12; p++) begin
      exp_an = exp_q.pop_front();
      check("an", 32'(an), 32'(exp_an));
      check("s", 32'(s), 32'((p < 6) ? s0 : s1));
      check("frame_start", 32'(frame_start), 32'((p == 0) ? fs0 : 1'b0));
      check("state", 32'(state_dbg), 32'(((p >= 2 && p <= 5) || p >= 8) ? 1'b1 : 1'b0));
      if (p == ph_a) begin
        load = 1'b1; digits = val_a;
      end else if (p == ph_b) begin
        load = 1'b1; digits = val_b;
      end else begin
        load = 1'b0; digits = 8'hEE;  // noise without load must not show
      end
      step();
    end
    load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    digits = 8'h00;
    repeat (2) step();
    reset = 1'b0;

    // Reset state, then an idle first frame with no frame_start.
    check("rst_an", 32'(an), 32'(2'b11));
    check("rst_s", 32'(s), 32'(4'h0));
    check("rst_fs", 32'(frame_start), 32'(1'b0));
    run_frame(4'h0, 4'h0, 1'b0, -1, 8'h00, -1, 8'h00);

    // Mid-frame load of A5 stays hidden until the boundary.
    run_frame(4'h0, 4'h0, 1'b1, 3, 8'hA5, -1, 8'h00);
    // A5 shown; two loads in this frame, the last (34) must win.
    run_frame(4'h5, 4'hA, 1'b1, 1, 8'h12, 7, 8'h34);
    // 34 shown; load 7C on the boundary edge itself.
    run_frame(4'h4, 4'h3, 1'b1, 11, 8'h7C, -1, 8'h00);
    // 7C shown immediately, and no stale pending value later.
    run_frame(4'hC, 4'h7, 1'b1, -1, 8'h00, -1, 8'h00);
    run_frame(4'hC, 4'h7, 1'b1, -1, 8'h00, -1, 8'h00);

    // Pending load of 99, then reset during digit 1's ON slot.
    for (int p = 0; p < 9; p++) begin
      if (p == 3) begin
        load = 1'b1; digits = 8'h99;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
    check("pre_rst_an", 32'(an), 32'(2'b01));
    reset = 1'b1;
    step();
    check("mid_rst_an", 32'(an), 32'(2'b11));
    check("mid_rst_s", 32'(s), 32'(4'h0));
    check("mid_rst_fs", 32'(frame_start), 32'(1'b0));
    check("mid_rst_state", 32'(state_dbg), 32'(1'b0));
    reset = 1'b0;
    run_frame(4'h0, 4'h0, 1'b0, -1, 8'h00, -1, 8'h00);
    run_frame(4'h0, 4'h0, 1'b1, 3, 8'h07, -1, 8'h00);
    // 07: digit 0 shows 7; digit 1 is dark only with leading-zero blanking.
    run_frame(4'h7, 4'h0, 1'b1, -1, 8'h00, -1, 8'h00);
    check("end_fs", 32'(frame_start), 32'(1'b1));
    check("end_an", 32'(an), 32'(2'b11));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
